spi_controller: RTL and testbench

//  SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit words.
//  On a start pulse it runs a burst of 1-4 full-duplex words, taking TX bytes from a 4-entry array.

---
 rtl/spi_pkg.sv | 9 +
 rtl/spi_sclk_gen.sv | 37 +++
 rtl/spi_controller.sv | 144 ++++++++++++++
 tb/tb_spi_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package spi_pkg;
  localparam int WORD_W    = 8;
  localparam int MAX_WORDS = 4;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, END} spi_state_t;
endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer for the SPI master: produces a registered SCLK and rise/fall strobes.
// Latency: tick every HALF_PERIOD clk cycles while en is high; SCLK toggles on that same edge.
// Backpressure: none; the counter restarts from zero whenever en is low.
// Ports: clk, rst_n; en (timer running), toggle_en (let SCLK toggle on ticks);
//        sclk (registered SPI clock), tick (half-period boundary), rise/fall (SCLK edge this cycle).
module spi_sclk_gen #(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic toggle_en,
  output logic sclk,
  output logic tick,
  output logic rise,
  output logic fall
);
  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(HALF_PERIOD - 1));
  // Strobes name the edge SCLK takes at the coming clk edge.
  assign rise = tick && toggle_en && !sclk;
  assign fall = tick && toggle_en && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      if (!en || tick) cnt <= '0;
      else             cnt <= cnt + CW'(1);
      if (tick && toggle_en) sclk <= ~sclk;
    end
  end
endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master, MSB first, bursts of 1-4 full-duplex bytes with tied or released SS.
// Latency: SS falls 1 clk after start; each word takes 16 SCLK half-periods; done pulses at end.
// Backpressure: start is ignored while busy; config is latched at start only.
// Ports: clk, rst_n; start, data_words (words-1), tied_SS, tx_data[0:3] from the register block;
//        rx_data[0:3], busy, done back to it; MISO in, MOSI/SCLK/SS out to the slave.
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        data_words,
  input  logic              tied_SS,
  input  logic [WORD_W-1:0] tx_data [0:MAX_WORDS-1],
  output logic [WORD_W-1:0] rx_data [0:MAX_WORDS-1],
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic              SS,
  output logic              busy,
  output logic              done
);
  localparam int BW = $clog2(WORD_W);

  spi_state_t        state;
  logic [WORD_W-1:0] tx_lat [0:MAX_WORDS-1];
  logic [1:0]        words_lat;
  logic              tied_lat;
  logic [1:0]        word_idx;
  logic [1:0]        next_idx;
  logic [BW-1:0]     bit_cnt;
  logic              gap_cnt;
  logic [WORD_W-1:0] tx_sh;
  // Holds the first 7 bits of a word; the 8th comes straight from MISO.
  logic [WORD_W-2:0] rx_sh;
  logic              tick, rise, fall;

  assign next_idx = word_idx + 2'd1;

  spi_sclk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_sclk (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state != IDLE),
    .toggle_en (state == SHIFT),
    .sclk      (SCLK),
    .tick      (tick),
    .rise      (rise),
    .fall      (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      SS        <= 1'b1;
      MOSI      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      words_lat <= '0;
      tied_lat  <= 1'b0;
      word_idx  <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      for (int i = 0; i < MAX_WORDS; i++) begin
        rx_data[i] <= '0;
        tx_lat[i]  <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < MAX_WORDS; i++) tx_lat[i] <= tx_data[i];
            words_lat <= data_words;
            tied_lat  <= tied_SS;
            word_idx  <= '0;
            bit_cnt   <= '0;
            tx_sh     <= tx_data[0];
            MOSI      <= tx_data[0][WORD_W-1];
            SS        <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (tick) state <= SHIFT;
        end
        SHIFT: begin
          if (rise) begin
            rx_sh <= {rx_sh[WORD_W-3:0], MISO};
            if (bit_cnt == BW'(WORD_W - 1)) rx_data[word_idx] <= {rx_sh, MISO};
          end
          if (fall) begin
            if (bit_cnt != BW'(WORD_W - 1)) begin
              bit_cnt <= bit_cnt + BW'(1);
              tx_sh   <= tx_sh << 1;
              MOSI    <= tx_sh[WORD_W-2];
            end else begin
              // Word boundary: SCLK is low again after this edge.
              bit_cnt <= '0;
              if (word_idx == words_lat) begin
                state <= END;
              end else begin
                word_idx <= next_idx;
                tx_sh    <= tx_lat[next_idx];
                if (tied_lat) begin
                  MOSI <= tx_lat[next_idx][WORD_W-1];
                end else begin
                  SS      <= 1'b1;
                  gap_cnt <= 1'b0;
                  state   <= GAP;
                end
              end
            end
          end
        end
        GAP: begin
          // SS stays high for two half-periods before reselecting the slave.
          if (tick) begin
            if (gap_cnt) begin
              SS    <= 1'b0;
              MOSI  <= tx_sh[WORD_W-1];
              state <= SETUP;
            end else begin
              gap_cnt <= 1'b1;
            end
          end
        end
        END: begin
          if (tick) begin
            SS    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_controller.sv
module tb_spi_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT a: HALF_PERIOD=1 with a modelled slave
  logic       start_a = 1'b0;
  logic [1:0] dw_a = 2'd0;
  logic       tied_a = 1'b0;
  logic [7:0] tx_a [0:3];
  logic [7:0] rx_a [0:3];
  logic       MISO_a = 1'b0;
  logic       MOSI_a, SCLK_a, SS_a, busy_a, done_a;

  // DUT b: HALF_PERIOD=4 with MISO looped back from MOSI
  logic       start_b = 1'b0;
  logic [1:0] dw_b = 2'd0;
  logic       tied_b = 1'b0;
  logic [7:0] tx_b [0:3];
  logic [7:0] rx_b [0:3];
  logic       MISO_b = 1'b0;
  logic       MOSI_b, SCLK_b, SS_b, busy_b, done_b;

  spi_controller #(.HALF_PERIOD(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .data_words(dw_a), .tied_SS(tied_a),
    .tx_data(tx_a), .rx_data(rx_a), .MISO(MISO_a), .MOSI(MOSI_a), .SCLK(SCLK_a),
    .SS(SS_a), .busy(busy_a), .done(done_a));

  spi_controller #(.HALF_PERIOD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .data_words(dw_b), .tied_SS(tied_b),
    .tx_data(tx_b), .rx_data(rx_b), .MISO(MISO_b), .MOSI(MOSI_b), .SCLK(SCLK_b),
    .SS(SS_b), .busy(busy_b), .done(done_b));

  int n_checks = 0;
  int n_fail = 0;

  // Slave / monitor state
  logic [7:0] resp [0:3];
  logic [7:0] got [$];
  logic [7:0] acc = 8'h00;
  int bitpos = 0, rises = 0, ss_rises = 0, hi_run = 0, gap_len = 0, done_cnt = 0;
  int cyc_now = 0, b_rises = 0, b_last = -1, b_period = 0;
  logic prev_sclk = 1'b0, prev_ss = 1'b1, prev_sclk_b = 1'b0;

  // Reference model of rx_data for DUT a
  logic [7:0] exp_rx [0:3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_at(input int pos);
    logic [7:0] r;
    if (pos / 8 >= 4) return 1'b0;
    r = resp[pos / 8];
    return r[7 - (pos % 8)];
  endfunction

  // Mode-0 slave: shifts MOSI in on SCLK rising, presents next MISO bit on SCLK falling / SS falling.
  initial begin
    forever begin
      @(negedge clk);
      cyc_now++;
      if (SCLK_a && !prev_sclk) begin
        rises++;
        acc = {acc[6:0], MOSI_a};
        bitpos++;
        if (bitpos % 8 == 0) got.push_back(acc);
      end
      if (!SCLK_a && prev_sclk && !SS_a) MISO_a = bit_at(bitpos);
      if (!SS_a && prev_ss) begin
        MISO_a = bit_at(bitpos);
        if (ss_rises > 0) gap_len = hi_run;
      end
      if (SS_a && !prev_ss) begin
        ss_rises++;
        hi_run = 0;
      end
      if (SS_a) hi_run++;
      if (done_a) done_cnt++;
      prev_sclk = SCLK_a;
      prev_ss = SS_a;
      MISO_b = MOSI_b;
      if (SCLK_b && !prev_sclk_b) begin
        b_rises++;
        if (b_last >= 0) b_period = cyc_now - b_last;
        b_last = cyc_now;
      end
      prev_sclk_b = SCLK_b;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slave();
    rises = 0; ss_rises = 0; gap_len = 0; done_cnt = 0; bitpos = 0; hi_run = 0;
    got.delete();
  endtask

  task automatic burst_a(input int nw, input bit tied, input bit disturb);
    logic [7:0] etx [0:3];
    logic [7:0] last;
    int cyc;
    clear_slave();
    for (int i = 0; i < 4; i++) etx[i] = tx_a[i];
    dw_a = 2'(nw - 1);
    tied_a = tied;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("ss_low_after_start", SS_a, 0);
    check("busy_after_start", busy_a, 1);
    cyc = 0;
    while (!done_a && cyc < 400) begin
      if (disturb && cyc == 20) begin
        start_a = 1'b1;
        for (int i = 0; i < 4; i++) tx_a[i] = ~tx_a[i];
        dw_a = ~dw_a;
        tied_a = ~tied_a;
      end else begin
        start_a = 1'b0;
      end
      step();
      cyc++;
    end
    start_a = 1'b0;
    check("done_seen", done_a, 1);
    check("busy_clear_at_done", busy_a, 0);
    step();
    check("done_one_cycle", done_a, 0);
    check("done_count", done_cnt, 1);
    check("ss_idle_high", SS_a, 1);
    check("sclk_idle_low", SCLK_a, 0);
    check("sclk_rises", rises, 8 * nw);
    check("ss_rise_count", ss_rises, tied ? 1 : nw);
    last = etx[nw - 1];
    check("mosi_holds_last", MOSI_a, last[0]);
    check("slave_byte_count", got.size(), nw);
    for (int i = 0; i < nw && i < got.size(); i++) check("slave_got_tx", got[i], etx[i]);
    for (int i = 0; i < nw; i++) exp_rx[i] = resp[i];
    for (int i = 0; i < 4; i++) check("rx_data", rx_a[i], exp_rx[i]);
    if (!tied && nw > 1) check("gap_ss_high_ge2", gap_len >= 2, 1);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 4; i++) begin
      tx_a[i] = 8'h00; tx_b[i] = 8'h00; resp[i] = 8'h00; exp_rx[i] = 8'h00;
    end

    // 1. Reset values
    repeat (3) step();
    check("rst_ss", SS_a, 1);
    check("rst_sclk", SCLK_a, 0);
    check("rst_mosi", MOSI_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    for (int i = 0; i < 4; i++) check("rst_rx", rx_a[i], 0);
    rst_n = 1'b1;
    repeat (2) step();

    // 2. Four-word tied burst
    tx_a[0] = 8'hFA; tx_a[1] = 8'hFB; tx_a[2] = 8'hFC; tx_a[3] = 8'hFE;
    resp[0] = 8'hA1; resp[1] = 8'hB2; resp[2] = 8'hC3; resp[3] = 8'hD4;
    burst_a(4, 1'b1, 1'b0);

    // 3. Two-word untied burst; entries 2..3 keep C3/D4
    for (int i = 0; i < 4; i++) begin
      tx_a[i] = 8'($urandom); resp[i] = 8'($urandom);
    end
    burst_a(2, 1'b0, 1'b0);
    repeat (3) step();

    // 4. Single word, HALF_PERIOD=4, loopback
    tx_b[0] = 8'h5A; tx_b[1] = 8'h33; dw_b = 2'd0; tied_b = 1'b0;
    b_rises = 0; b_last = -1; b_period = 0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check("b_ss_low_after_start", SS_b, 0);
    cyc = 0;
    while (!done_b && cyc < 300) begin
      step();
      cyc++;
    end
    check("b_done_seen", done_b, 1);
    check("b_rx0_loopback", rx_b[0], 8'h5A);
    check("b_rx1_untouched", rx_b[1], 8'h00);
    check("b_sclk_rises", b_rises, 8);
    check("b_sclk_period", b_period, 8);
    repeat (3) step();

    // 5. Mid-burst start and tx/config changes are ignored
    for (int i = 0; i < 4; i++) begin
      tx_a[i] = 8'($urandom); resp[i] = 8'($urandom);
    end
    burst_a(4, 1'b1, 1'b1);
    repeat (3) step();

    // Randomized bursts against the model
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        tx_a[i] = 8'($urandom); resp[i] = 8'($urandom);
      end
      burst_a(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b0);
      repeat (2) step();
    end

    // 6. Reset mid-word aborts, then a clean burst
    for (int i = 0; i < 4; i++) begin
      tx_a[i] = 8'($urandom); resp[i] = 8'($urandom);
    end
    clear_slave();
    dw_a = 2'd3; tied_a = 1'b1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (10) step();
    check("mid_burst_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("abort_ss", SS_a, 1);
    check("abort_sclk", SCLK_a, 0);
    check("abort_mosi", MOSI_a, 0);
    check("abort_busy", busy_a, 0);
    for (int i = 0; i < 4; i++) begin
      exp_rx[i] = 8'h00;
      check("abort_rx", rx_a[i], 0);
    end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 4; i++) begin
      tx_a[i] = 8'($urandom); resp[i] = 8'($urandom);
    end
    burst_a(3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
